// File: rtl/demux_four_stream_pkg.sv
// demux_pkg: definitions shared by the 1-to-4 stream demultiplexer and the
// 4-to-1 mux32four selector.
//   lane_sel_t : 2-bit lane identifier LANE0..LANE3
//   NUM_LANES  : number of output lanes
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2,
    LANE3 = 2'd3
  } lane_sel_t;

endpackage

// File: rtl/demux_four_stream_if.sv
// demux_four_stream_if: bundles the input stream, the four output lanes, the
// counter clear and the flattened counters of demux_four_stream.
//   in_valid/in_ready/in_data/in_sel : upstream valid/ready port with lane select
//   out_valid/out_ready/out_data     : four downstream lanes, lane k at [k*N +: N]
//   cnt_clr/count                    : counter clear, lane k count at [k*CNTW +: CNTW]
// modport slave is the demux side, modport master is the environment side.
interface demux_four_stream_if #(
  parameter int N    = 32,
  parameter int CNTW = 16
);
  import demux_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [N-1:0]              in_data;
  lane_sel_t                 in_sel;
  logic [NUM_LANES-1:0]      out_valid;
  logic [NUM_LANES-1:0]      out_ready;
  logic [NUM_LANES*N-1:0]    out_data;
  logic                      cnt_clr;
  logic [NUM_LANES*CNTW-1:0] count;

  modport slave (
    input  in_valid, in_data, in_sel, out_ready, cnt_clr,
    output in_ready, out_valid, out_data, count
  );

  modport master (
    output in_valid, in_data, in_sel, out_ready, cnt_clr,
    input  in_ready, out_valid, out_data, count
  );

endinterface

// File: rtl/demux_four_stream_slot.sv
// demux_slot: one-entry valid/ready holding register with a wrapping count of
// words delivered downstream.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : write data_i into the slot this edge (caller guarantees space)
//   data_i    : word to load
//   ready_i   : downstream consumer accepts
//   clr_i     : synchronous counter clear, wins over an increment
//   valid_o   : slot holds a word
//   data_o    : held word (keeps its last value after draining)
//   count_o   : delivered-word count, wraps at 2^CNTW
module demux_slot #(
  parameter int N    = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [N-1:0]    data_i,
  input  logic            ready_i,
  input  logic            clr_i,
  output logic            valid_o,
  output logic [N-1:0]    data_o,
  output logic [CNTW-1:0] count_o
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic            valid_q, valid_d;
  logic [N-1:0]    data_q, data_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            fire;

  assign fire = valid_q && ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    // A load on the same edge as a drain keeps the slot full with new data.
    if (fire)   valid_d = 1'b0;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
    if (fire)  count_d = count_q + CNT_ONE;
    if (clr_i) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

// File: rtl/demux_four_stream.sv
// demux_four_stream: 1-to-4 valid/ready stream demultiplexer. Each accepted
// word is steered by in_sel into that lane's one-entry slot and held until the
// lane consumer takes it. Each lane counts its delivered words.
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset; in_ready is forced low while high
//   bus  : demux_four_stream_if.slave carrying the input port, the four
//          output lanes, cnt_clr and the flattened counters
module demux_four_stream
  import demux_pkg::*;
#(
  parameter int N    = 32,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  demux_four_stream_if.slave    bus
);

  logic [NUM_LANES-1:0] lane_space;
  logic [NUM_LANES-1:0] lane_load;
  logic [NUM_LANES-1:0] lane_valid;
  logic [N-1:0]         lane_data  [NUM_LANES];
  logic [CNTW-1:0]      lane_count [NUM_LANES];
  logic                 accept;

  // Only the selected lane can block the input; in_valid plays no part.
  assign bus.in_ready = !rst && lane_space[bus.in_sel];
  assign accept       = bus.in_valid && bus.in_ready;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_space[k] = !lane_valid[k] || bus.out_ready[k];
    assign lane_load[k]  = accept && (bus.in_sel == lane_sel_t'(k));

    demux_slot #(
      .N    (N),
      .CNTW (CNTW)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .load_i  (lane_load[k]),
      .data_i  (bus.in_data),
      .ready_i (bus.out_ready[k]),
      .clr_i   (bus.cnt_clr),
      .valid_o (lane_valid[k]),
      .data_o  (lane_data[k]),
      .count_o (lane_count[k])
    );

    assign bus.out_data[k*N +: N]       = lane_data[k];
    assign bus.count[k*CNTW +: CNTW]    = lane_count[k];
  end

  assign bus.out_valid = lane_valid;

endmodule

// File: tb/tb_demux_four_stream.sv
module tb_demux_four_stream;
  import demux_pkg::*;

  localparam int N    = 32;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_four_stream_if #(.N(N), .CNTW(CNTW)) bus ();

  demux_four_stream #(.N(N), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-lane occupancy, last word, delivered count.
  bit          m_v [4];
  logic [31:0] m_d [4];
  int          m_c [4];

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [31:0] d;
    logic [3:0]  ordy;
    logic        clr;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    logic [1:0]  lane;
    logic [31:0] exp_word;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic bit m_rdy(input logic [1:0] sel, input logic [3:0] ordy);
    return !m_v[sel] || ordy[sel];
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin
      m_v[k] = 1'b0;
      m_d[k] = '0;
      m_c[k] = 0;
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lane%0d_valid", k), 64'(bus.out_valid[k]), 64'(m_v[k]));
      chk($sformatf("lane%0d_data", k), 64'(bus.out_data[k*N +: N]), 64'(m_d[k]));
      chk($sformatf("lane%0d_count", k), 64'(bus.count[k*CNTW +: CNTW]), 64'(m_c[k]));
    end
  endtask

  // One clock: drive, check in_ready before the edge, advance model, check after.
  task automatic step(input logic v, input logic [1:0] sel, input logic [31:0] d,
                      input logic [3:0] ordy, input logic clr, output logic rdy_seen);
    bit acc;
    bus.in_valid  = v;
    bus.in_sel    = lane_sel_t'(sel);
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.cnt_clr   = clr;
    #2;
    rdy_seen = bus.in_ready;
    chk("in_ready", 64'(rdy_seen), 64'(m_rdy(sel, ordy)));
    acc = v && m_rdy(sel, ordy);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (m_v[k] && ordy[k]) begin
        m_v[k] = 1'b0;
        m_c[k] = (m_c[k] + 1) % (1 << CNTW);
      end
    end
    if (clr) for (int k = 0; k < 4; k++) m_c[k] = 0;
    if (acc) begin
      m_v[sel] = 1'b1;
      m_d[sel] = d;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    logic r;

    tbl[0]  = '{1'b1, 2'd0, 32'hA,  4'hF, 1'b0, 1'b1, 4'b0001, 2'd0, 32'hA,  16'h0000};
    tbl[1]  = '{1'b1, 2'd1, 32'hB,  4'hF, 1'b0, 1'b1, 4'b0010, 2'd1, 32'hB,  16'h0001};
    tbl[2]  = '{1'b1, 2'd2, 32'hC,  4'hF, 1'b0, 1'b1, 4'b0100, 2'd2, 32'hC,  16'h0011};
    tbl[3]  = '{1'b1, 2'd3, 32'hD,  4'hF, 1'b0, 1'b1, 4'b1000, 2'd3, 32'hD,  16'h0111};
    tbl[4]  = '{1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 1'b1, 4'b0000, 2'd3, 32'hD,  16'h1111};
    tbl[5]  = '{1'b1, 2'd1, 32'h11, 4'hD, 1'b0, 1'b1, 4'b0010, 2'd1, 32'h11, 16'h1111};
    tbl[6]  = '{1'b1, 2'd1, 32'h22, 4'hD, 1'b0, 1'b0, 4'b0010, 2'd1, 32'h11, 16'h1111};
    tbl[7]  = '{1'b1, 2'd0, 32'h55, 4'hD, 1'b0, 1'b1, 4'b0011, 2'd0, 32'h55, 16'h1111};
    tbl[8]  = '{1'b1, 2'd1, 32'h22, 4'hF, 1'b0, 1'b1, 4'b0010, 2'd1, 32'h22, 16'h1122};
    tbl[9]  = '{1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 1'b1, 4'b0000, 2'd1, 32'h22, 16'h1132};
    tbl[10] = '{1'b1, 2'd3, 32'h77, 4'h7, 1'b0, 1'b1, 4'b1000, 2'd3, 32'h77, 16'h1132};
    tbl[11] = '{1'b1, 2'd3, 32'h33, 4'hF, 1'b0, 1'b1, 4'b1000, 2'd3, 32'h33, 16'h2132};
    tbl[12] = '{1'b0, 2'd0, 32'h0,  4'hF, 1'b0, 1'b1, 4'b0000, 2'd3, 32'h33, 16'h3132};

    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sel    = LANE0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    bus.cnt_clr   = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    rst = 1'b0;

    // Table: routing, backpressure, same-edge drain/reload.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy, tbl[i].clr, r);
      chk($sformatf("tbl%0d_in_ready", i), 64'(r), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_out_valid", i), 64'(bus.out_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_word", i), 64'(bus.out_data[tbl[i].lane*N +: N]), 64'(tbl[i].exp_word));
      chk($sformatf("tbl%0d_count", i), 64'(bus.count), 64'(tbl[i].exp_cnt));
    end

    // Counter wrap: 17 handshakes on lane 0 with a 4-bit counter.
    step(1'b0, 2'd0, 32'h0, 4'hF, 1'b1, r);
    chk("clr_all_counts", 64'(bus.count), 64'd0);
    for (int i = 0; i < 17; i++) step(1'b1, 2'd0, 32'h100 + 32'(i), 4'hF, 1'b0, r);
    step(1'b0, 2'd0, 32'h0, 4'hF, 1'b0, r);
    chk("wrap_count0", 64'(bus.count[CNTW-1:0]), 64'd1);

    // Clear on the same edge as a lane 0 handshake.
    step(1'b1, 2'd0, 32'h99, 4'hF, 1'b0, r);
    chk("clr_pre_valid0", 64'(bus.out_valid[0]), 64'd1);
    chk("clr_pre_data0", 64'(bus.out_data[N-1:0]), 64'h99);
    step(1'b0, 2'd0, 32'h0, 4'hF, 1'b1, r);
    chk("clr_same_edge_count0", 64'(bus.count[CNTW-1:0]), 64'd0);
    chk("clr_word_delivered", 64'(bus.out_valid[0]), 64'd0);

    // Reset asserted mid-cycle with lanes 1 and 3 full.
    step(1'b1, 2'd1, 32'h111, 4'h0, 1'b0, r);
    step(1'b1, 2'd3, 32'h333, 4'h0, 1'b0, r);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'b1010);
    bus.in_valid = 1'b1;
    bus.in_sel   = LANE2;
    #2;
    rst = 1'b1;
    #1;
    m_reset();
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_data_zero", 64'(bus.out_data == '0), 64'd1);
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 2'd2, 32'hA, 4'h0, 1'b0, r);
    chk("post_rst_accept", 64'(r), 64'd1);
    chk("post_rst_valid", 64'(bus.out_valid), 64'b0100);
    chk("post_rst_lane2", 64'(bus.out_data[2*N +: N]), 64'hA);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), $urandom,
           4'($urandom_range(0, 15)), ($urandom_range(0, 15) == 0), r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
